hazard_stall_ctrl: RTL

Parametrised successor of the pipeline hazard unit for the 5-stage RV32 core.
- Detects load-use hazards with x0 exclusion and rs-used qualification.
- Inserts a configurable number of bubbles via a counter FSM.
- Freezes the pipeline on data-memory wait or a busy multi-cycle EX unit.
- Flushes IF/ID and ID/EX on an EX-stage redirect.
- Sits beside the ID stage and drives every pipeline-register enable and flush.

---
 rtl/hazard_stall_ctrl_pkg.sv | 14 +
 rtl/hazard_stall_ctrl_if.sv | 43 ++++
 rtl/hazard_stall_ctrl_perf_counters.sv | 38 +++
 rtl/hazard_stall_ctrl.sv | 128 ++++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the ID-stage hazard/stall controller.
`timescale 1ns/1ps
package hazard_pkg;

  typedef enum logic [0:0] {
    IDLE       = 1'b0,
    LOAD_STALL = 1'b1
  } hz_state_e;

  localparam int REG_X0             = 0;
  localparam int DEFAULT_REG_ADDR_W = 5;
  localparam int BUBBLE_CNT_W       = 3;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline <-> hazard unit bundle: hazard sources in, register enables/flushes out.
`timescale 1ns/1ps
interface hazard_stall_ctrl_if
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
);

  logic [REG_ADDR_W-1:0] idex_rd;
  logic                  idex_mem_read;
  logic [REG_ADDR_W-1:0] ifid_rs1;
  logic [REG_ADDR_W-1:0] ifid_rs2;
  logic                  ifid_rs1_used;
  logic                  ifid_rs2_used;
  logic                  ex_redirect;
  logic                  ex_busy;
  logic                  mem_stall;

  logic                  pc_write;
  logic                  ifid_write;
  logic                  idex_write;
  logic                  exmem_write;
  logic                  ifid_flush;
  logic                  idex_flush;
  logic                  exmem_flush;
  logic                  stall_active;

  // Pipeline side reports hazard sources and consumes the controls.
  modport master (
    output idex_rd, idex_mem_read, ifid_rs1, ifid_rs2, ifid_rs1_used, ifid_rs2_used,
           ex_redirect, ex_busy, mem_stall,
    input  pc_write, ifid_write, idex_write, exmem_write,
           ifid_flush, idex_flush, exmem_flush, stall_active
  );

  modport slave (
    input  idex_rd, idex_mem_read, ifid_rs1, ifid_rs2, ifid_rs1_used, ifid_rs2_used,
           ex_redirect, ex_busy, mem_stall,
    output pc_write, ifid_write, idex_write, exmem_write,
           ifid_flush, idex_flush, exmem_flush, stall_active
  );

endinterface

// File: rtl/hazard_stall_ctrl_perf_counters.sv
// Stall-cycle and redirect counters; only present when HAZARD_PERF_EN is defined.
`timescale 1ns/1ps
`ifdef HAZARD_PERF_EN
module hazard_perf_counters #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_evt,
  input  logic              flush_evt,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
);

  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

  // Free-running counters that wrap naturally at 2^PERF_W.
  always_comb begin
    stall_cnt_d = stall_cnt_q + PERF_W'(stall_evt);
    flush_cnt_d = flush_cnt_q + PERF_W'(flush_evt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
`endif

// File: rtl/hazard_stall_ctrl.sv
// Load-use / freeze / redirect controller beside the ID stage of the 5-stage RV32 core.
// Optional performance counters are enabled with the HAZARD_PERF_EN macro.
`timescale 1ns/1ps
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W   = DEFAULT_REG_ADDR_W,
  parameter int LOAD_BUBBLES = 1,
  parameter int PERF_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  hazard_stall_ctrl_if.slave bus,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt
);

  if (LOAD_BUBBLES < 1 || LOAD_BUBBLES > ((1 << BUBBLE_CNT_W) - 1)) begin : g_bad_cfg
    $error("hazard_stall_ctrl: LOAD_BUBBLES must be in 1..7");
  end

  hz_state_e               state_q, state_d;
  logic [BUBBLE_CNT_W-1:0] cnt_q, cnt_d;
  logic                    hz;
  logic                    pc_write, ifid_write, idex_write, exmem_write;
  logic                    ifid_flush, idex_flush, exmem_flush;

  // x0 never creates a dependency; a source only matters if the ID instruction reads it.
  assign hz = bus.idex_mem_read && (bus.idex_rd != REG_ADDR_W'(REG_X0)) &&
              ((bus.ifid_rs1_used && (bus.idex_rd == bus.ifid_rs1)) ||
               (bus.ifid_rs2_used && (bus.idex_rd == bus.ifid_rs2)));

  // Freezes hold the bubble counter, so only unfrozen cycles count towards the stall.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      state_d     = IDLE;
      cnt_d       = '0;
    end else if (bus.mem_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
    end else if (bus.ex_busy) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_flush = 1'b1;
    end else if (bus.ex_redirect) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      state_d     = IDLE;
      cnt_d       = '0;
    end else if ((state_q == LOAD_STALL) || hz) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_flush  = 1'b1;
      if (state_q == IDLE) begin
        if (LOAD_BUBBLES > 1) begin
          state_d = LOAD_STALL;
          cnt_d   = BUBBLE_CNT_W'(LOAD_BUBBLES - 1);
        end
      end else if (cnt_q == BUBBLE_CNT_W'(1)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q - BUBBLE_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc_write     = pc_write;
  assign bus.ifid_write   = ifid_write;
  assign bus.idex_write   = idex_write;
  assign bus.exmem_write  = exmem_write;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_flush   = idex_flush;
  assign bus.exmem_flush  = exmem_flush;
  assign bus.stall_active = (state_q == LOAD_STALL) && !rst;

`ifdef HAZARD_PERF_EN
  logic stall_evt, flush_evt;

  // A redirect only counts when no freeze outranks it.
  assign stall_evt = !pc_write && !rst;
  assign flush_evt = bus.ex_redirect && !bus.mem_stall && !bus.ex_busy && !rst;

  hazard_perf_counters #(
    .PERF_W(PERF_W)
  ) u_perf (
    .clk      (clk),
    .rst      (rst),
    .stall_evt(stall_evt),
    .flush_evt(flush_evt),
    .stall_cnt(perf_stall_cnt),
    .flush_cnt(perf_flush_cnt)
  );
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule
